vga_multiball_engine: RTL and testbench
=======================================

# vga_multiball_engine

Sprite layer for the VGA demo: animates N_BALLS independent bouncing balls, each with its own step size, direction and palette colour, and composites them, plus optional drop shadows, over a background colour supplied by the upstream text/background layer. It sits between the hvsync generator's pixel coordinates and the 6-bit RGB output mux. Positions update once per frame through a serial update sequencer. Per-pixel hit testing is a 2-stage pipeline using bounding-box pre-check and small squared-distance arithmetic.

## Interface
- N_BALLS, 4: number of balls; legal range 1..4.
- RADIUS, 20: ball radius in pixels; legal range 4..24.
- SHADOW_W, 4: shadow ring width in pixels; RADIUS+SHADOW_W ≤ 31.
- H_ACTIVE, 640: visible width.
- V_ACTIVE, 480: visible height.
- clk  in  1  pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- frame_start  in  1  one-cycle pulse at x==0, y==0.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- video_active  in  1  visible-area flag, aligned with x/y.
- bg_rgb  in  6  background colour {R[1:0],G[1:0],B[1:0]}, aligned with x/y.
- pause  in  1  high: position updates suppressed.
- speed_sel  in  2  step multiplier shift; 3 is treated as 2.
- rgb  out  6  composited colour, 2 cycles after inputs.
- hit  out  1  a ball body covers the pixel; aligned with rgb.
- update_busy  out  1  update sequencer active.
- overrun  out  1  sticky: frame_start arrived while busy. Cleared only by reset.

## Operation
- Per-ball state: bx, by (10 b), dir_x, dir_y (1 = +).
- Reset values:
  - bx_i = 160 + 96·i, by_i = 120 + 64·i.
  - dir_x_i = ~i[0], dir_y_i = i[1].
  - All outputs 0.
- Step sizes:
  - step_x_i = (1 + i mod 3) << s.
  - step_y_i = (2 + i mod 2) << s.
  - s = min(speed_sel, 2).
- Bounds:
  - LO = RADIUS.
  - HI_X = H_ACTIVE-1-RADIUS.
  - HI_Y = V_ACTIVE-1-RADIUS.
- Update FSM with states IDLE and UPDATE, and a counter idx.
  - IDLE → UPDATE on frame_start && !pause. idx resets to 0.
  - UPDATE handles ball idx in one cycle, then idx increments.
  - After idx == N_BALLS-1, return to IDLE.
  - update_busy = (state == UPDATE).
- Per-axis update with clamping, no overshoot:
  - Moving +: next = p + step. If next ≥ HI, then p ← HI and dir ← 0. Otherwise p ← next.
  - Moving −: if p ≤ LO + step, then p ← LO and dir ← 1. Otherwise p ← p − step.
  - All arithmetic is 11-bit to avoid wrap.
- frame_start while UPDATE: ignored, overrun ← 1.
- pause changes have no effect on an in-progress UPDATE.
- Pixel stage 1, per ball (registered):
  - dx = |x − bx|, dy = |y − by|.
  - in_box = dx ≤ RADIUS+SHADOW_W && dy ≤ RADIUS+SHADOW_W.
  - Store dx, dy truncated to 5 b, plus in_box.
  - video_active and bg_rgb are delayed alongside.
- Pixel stage 2 (registered):
  - d2 = dx² + dy², 11 b.
  - body_i = in_box && d2 ≤ RADIUS².
  - shad_i = in_box && d2 ≤ (RADIUS+SHADOW_W)².
- Output priority:
  1. !video_active_d2 → rgb 0.
  2. Lowest-index body → PALETTE[i].
  3. Any shadow → SHADOW_RGB.
  4. Otherwise bg_rgb_d2.
- hit = any body_i && video_active_d2.
- Positions may change mid-frame only if frame_start is issued elsewhere. The pixel path reads the current registers with no double-buffering.

## Timing
- rgb and hit latency: exactly 2 clk after x/y/video_active/bg_rgb. The integrator delays hsync/vsync by 2.
- Update: N_BALLS cycles starting the cycle after frame_start. New positions are visible to the pixel path from the cycle they are written.
- Reset asserted mid-UPDATE: all state returns to reset values immediately. FSM goes to IDLE.
- frame_start and reset deassertion in the same cycle: pulse ignored.

## Configuration
- VGA_BALL_SHADOW_EN defined:
  - Shadow ring is rendered.
  - in_box uses RADIUS+SHADOW_W.
- Not defined:
  - No shadow compare logic. Shadow priority level removed.
  - in_box uses RADIUS.
  - SHADOW_W is unused.

## Structure
- Package vga_pkg holds:
  - RGB_W = 6.
  - PALETTE[0..3] = 11_10_00, 00_11_11, 11_00_11, 00_11_00.
  - SHADOW_RGB = 01_01_01.
  - BLACK = 0.
  - Ball state struct: bx, by, dir_x, dir_y.
- One sub-module: vga_ball_hit. It implements the per-ball stage-1/stage-2 distance test and is instantiated N_BALLS times.

## Test plan
- Reset, then x=160, y=120, video_active=1, bg=000010. After 2 cycles: rgb=111000, hit=1. Pixel x=300, y=5: rgb=000010, hit=0.
- N_BALLS=1, speed_sel=0, ball 0 at bx=HI_X-1 moving +, frame_start: bx=619, dir_x=0. Next frame: bx=618.
- Ball at bx=21 moving −, step 2: clamps to bx=20, dir_x=1. Never below 20.
- Two balls overlapping at the test pixel: rgb is PALETTE[0].
- With VGA_BALL_SHADOW_EN, pixel at distance 22 from ball 0: rgb=010101, hit=0. Without the macro: rgb=bg.
- frame_start pulses 2 cycles apart with N_BALLS=4: overrun=1, and only one update occurs. pause=1 then frame_start: positions unchanged, update_busy stays 0.

Source files
------------

// File: rtl/vga_multiball_engine_pkg.sv
// vga_pkg: shared definitions for the multiball sprite engine.
//   - RGB_W, BLACK, SHADOW_RGB and the four-entry ball PALETTE
//   - ball_t: per-ball position and direction state
//   - ball_reset(): power-on placement of ball i
//   - axis_step(): one clamped bounce step along a single axis
// Optional feature macro: VGA_BALL_SHADOW_EN (renders a drop-shadow ring).
package vga_pkg;

  localparam int RGB_W = 6;
  localparam logic [RGB_W-1:0] BLACK      = '0;
  localparam logic [RGB_W-1:0] SHADOW_RGB = 6'b01_01_01;

  // Entry i is the colour of ball i, packed {R[1:0],G[1:0],B[1:0]}.
  localparam logic [3:0][RGB_W-1:0] PALETTE = {6'b00_11_00, 6'b11_00_11,
                                               6'b00_11_11, 6'b11_10_00};

`ifdef VGA_BALL_SHADOW_EN
  localparam bit SHADOW_ON = 1'b1;
`else
  localparam bit SHADOW_ON = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic       dir_x;
    logic       dir_y;
  } ball_t;

  // Balls start spread diagonally with alternating directions so they
  // separate immediately after the first frame.
  function automatic ball_t ball_reset(input int i);
    ball_t b;
    b.bx    = 10'(160 + 96 * i);
    b.by    = 10'(120 + 64 * i);
    b.dir_x = ~i[0];
    b.dir_y = i[1];
    return b;
  endfunction

  // Returns {new_dir, new_pos}. Works in 11 bits so p + step can never wrap,
  // and clamps onto the bound instead of overshooting it.
  function automatic logic [10:0] axis_step(input logic [9:0]  p,
                                            input logic        dir,
                                            input logic [10:0] step,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
    logic [10:0] p_ext;
    logic [10:0] nxt;
    logic [10:0] res;
    p_ext = {1'b0, p};
    nxt   = p_ext + step;
    if (dir) begin
      if (nxt >= hi) res = {1'b0, hi[9:0]};
      else           res = {1'b1, nxt[9:0]};
    end else begin
      if (p_ext <= lo + step) res = {1'b1, lo[9:0]};
      else                    res = {1'b0, p - step[9:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_multiball_engine_if.sv
// vga_multiball_engine_if: pixel-stream and control bundle of the sprite layer.
//   master: drives frame_start, x, y, video_active, bg_rgb, pause, speed_sel;
//           receives rgb, hit, update_busy, overrun.
//   slave : the engine side (mirror of master).
interface vga_multiball_engine_if;
  import vga_pkg::*;

  logic             frame_start;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             video_active;
  logic [RGB_W-1:0] bg_rgb;
  logic             pause;
  logic [1:0]       speed_sel;
  logic [RGB_W-1:0] rgb;
  logic             hit;
  logic             update_busy;
  logic             overrun;

  modport master (output frame_start, x, y, video_active, bg_rgb, pause, speed_sel,
                  input  rgb, hit, update_busy, overrun);
  modport slave  (input  frame_start, x, y, video_active, bg_rgb, pause, speed_sel,
                  output rgb, hit, update_busy, overrun);
endinterface

// File: rtl/vga_multiball_engine_ball_hit.sv
// vga_ball_hit: two-stage distance test of the current pixel against one ball.
//   clk, rst_n : pixel clock, async active-low reset
//   x, y       : current pixel coordinate
//   bx, by     : ball centre (live register values, no double-buffering)
//   body       : pixel lies inside the ball, 2 cycles after x/y
//   shad       : pixel lies inside the shadow ring radius (VGA_BALL_SHADOW_EN only)
// Stage 1 registers |dx|, |dy| and a bounding-box flag; stage 2 registers the
// squared-distance compares. The box check guarantees dx, dy fit in 5 bits.
module vga_ball_hit
  import vga_pkg::*;
#(
  parameter int RADIUS   = 20,
  parameter int SHADOW_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] bx,
  input  logic [9:0] by,
`ifdef VGA_BALL_SHADOW_EN
  output logic       shad,
`endif
  output logic       body
);

  localparam int         BOX   = RADIUS + (SHADOW_ON ? SHADOW_W : 0);
  localparam logic [9:0] BOX_L = 10'(BOX);
  localparam logic [10:0] R2   = 11'(RADIUS * RADIUS);
`ifdef VGA_BALL_SHADOW_EN
  localparam logic [10:0] S2   = 11'(BOX * BOX);
`endif

  logic [9:0]  dx_full, dy_full;
  logic [4:0]  dx_d, dx_q, dy_d, dy_q;
  logic        in_box_d, in_box_q;
  logic [10:0] dx_ext, dy_ext, d2;
  logic        body_d, body_q;
`ifdef VGA_BALL_SHADOW_EN
  logic        shad_d, shad_q;
`endif

  always_comb begin
    dx_full  = (x >= bx) ? (x - bx) : (bx - x);
    dy_full  = (y >= by) ? (y - by) : (by - y);
    in_box_d = (dx_full <= BOX_L) && (dy_full <= BOX_L);
    dx_d     = dx_full[4:0];
    dy_d     = dy_full[4:0];
    dx_ext   = {6'b0, dx_q};
    dy_ext   = {6'b0, dy_q};
    d2       = dx_ext * dx_ext + dy_ext * dy_ext;
    body_d   = in_box_q && (d2 <= R2);
`ifdef VGA_BALL_SHADOW_EN
    shad_d   = in_box_q && (d2 <= S2);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q     <= '0;
      dy_q     <= '0;
      in_box_q <= 1'b0;
      body_q   <= 1'b0;
`ifdef VGA_BALL_SHADOW_EN
      shad_q   <= 1'b0;
`endif
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      in_box_q <= in_box_d;
      body_q   <= body_d;
`ifdef VGA_BALL_SHADOW_EN
      shad_q   <= shad_d;
`endif
    end
  end

  assign body = body_q;
`ifdef VGA_BALL_SHADOW_EN
  assign shad = shad_q;
`endif

endmodule

// File: rtl/vga_multiball_engine.sv
// vga_multiball_engine: animates N_BALLS bouncing balls and composites them
// over the upstream background colour.
//   clk, rst_n : pixel clock, async active-low reset
//   bus (slave): frame_start/x/y/video_active/bg_rgb/pause/speed_sel in,
//                rgb/hit (2-cycle latency), update_busy, sticky overrun out
// Positions are updated one ball per cycle after each accepted frame_start.
// Optional feature macro: VGA_BALL_SHADOW_EN (drop-shadow ring under balls).
module vga_multiball_engine
  import vga_pkg::*;
#(
  parameter int N_BALLS  = 4,
  parameter int RADIUS   = 20,
  parameter int SHADOW_W = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input logic                  clk,
  input logic                  rst_n,
  vga_multiball_engine_if.slave bus
);

  localparam logic [10:0] LO   = 11'(RADIUS);
  localparam logic [10:0] HI_X = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] HI_Y = 11'(V_ACTIVE - 1 - RADIUS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic                     overrun_q, overrun_d;
  logic                     rst_done_q;
  ball_t [N_BALLS-1:0]      balls_q, balls_d;
  logic [1:0]               shift;
  logic [10:0]              step_x, step_y;
  logic [10:0]              nx, ny;

  logic                     va_p1_d, va_p1_q, va_p2_d, va_p2_q;
  logic [RGB_W-1:0]         bg_p1_d, bg_p1_q, bg_p2_d, bg_p2_q;
  logic [N_BALLS-1:0]       body;
`ifdef VGA_BALL_SHADOW_EN
  logic [N_BALLS-1:0]       shad;
`endif
  logic [RGB_W-1:0]         rgb_c;
  logic                     hit_c;

  // Step sizes depend on the ball being updated; speed_sel 3 saturates to 2.
  always_comb begin
    shift = (bus.speed_sel == 2'd3) ? 2'd2 : bus.speed_sel;
    case (idx_q)
      2'd1:    step_x = 11'd2;
      2'd2:    step_x = 11'd3;
      default: step_x = 11'd1;
    endcase
    step_x = step_x << shift;
    step_y = (idx_q[0] ? 11'd3 : 11'd2) << shift;
  end

  // Update sequencer. rst_done_q masks a frame_start coinciding with the
  // first clock after reset release.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    balls_d   = balls_q;
    nx        = '0;
    ny        = '0;
    if (state_q == ST_IDLE) begin
      if (bus.frame_start && rst_done_q && !bus.pause) begin
        state_d = ST_UPDATE;
        idx_d   = 2'd0;
      end
    end else begin
      if (bus.frame_start) overrun_d = 1'b1;
      for (int i = 0; i < N_BALLS; i++) begin
        if (idx_q == 2'(i)) begin
          nx = axis_step(balls_q[i].bx, balls_q[i].dir_x, step_x, LO, HI_X);
          ny = axis_step(balls_q[i].by, balls_q[i].dir_y, step_y, LO, HI_Y);
          balls_d[i].bx    = nx[9:0];
          balls_d[i].dir_x = nx[10];
          balls_d[i].by    = ny[9:0];
          balls_d[i].dir_y = ny[10];
        end
      end
      if (idx_q == 2'(N_BALLS - 1)) state_d = ST_IDLE;
      else                          idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      overrun_q  <= 1'b0;
      rst_done_q <= 1'b0;
      for (int i = 0; i < N_BALLS; i++) balls_q[i] <= ball_reset(i);
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      rst_done_q <= 1'b1;
      balls_q    <= balls_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_BALLS; g++) begin : g_ball
      vga_ball_hit #(
        .RADIUS   (RADIUS),
        .SHADOW_W (SHADOW_W)
      ) u_hit (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (bus.x),
        .y     (bus.y),
        .bx    (balls_q[g].bx),
        .by    (balls_q[g].by),
`ifdef VGA_BALL_SHADOW_EN
        .shad  (shad[g]),
`endif
        .body  (body[g])
      );
    end
  endgenerate

  // video_active and background ride alongside the two hit-test stages.
  always_comb begin
    va_p1_d = bus.video_active;
    bg_p1_d = bus.bg_rgb;
    va_p2_d = va_p1_q;
    bg_p2_d = bg_p1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_p1_q <= 1'b0;
      va_p2_q <= 1'b0;
      bg_p1_q <= '0;
      bg_p2_q <= '0;
    end else begin
      va_p1_q <= va_p1_d;
      va_p2_q <= va_p2_d;
      bg_p1_q <= bg_p1_d;
      bg_p2_q <= bg_p2_d;
    end
  end

  // Later assignments win: background, then shadow, then bodies from the
  // highest index down so the lowest-index ball ends on top.
  always_comb begin
    rgb_c = BLACK;
    hit_c = 1'b0;
    if (va_p2_q) begin
      rgb_c = bg_p2_q;
`ifdef VGA_BALL_SHADOW_EN
      if (|shad) rgb_c = SHADOW_RGB;
`endif
      for (int i = N_BALLS - 1; i >= 0; i--) begin
        if (body[i]) rgb_c = PALETTE[i];
      end
      hit_c = |body;
    end
  end

  assign bus.rgb         = rgb_c;
  assign bus.hit         = hit_c;
  assign bus.update_busy = (state_q == ST_UPDATE);
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_vga_multiball_engine.sv
// Directed bench for vga_multiball_engine: a 4-ball instance for pixel,
// sequencer and overrun behaviour, and a 1-ball instance for wall bounces.
module tb_vga_multiball_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int mbx[4], mby[4], mdx[4], mdy[4];
  logic [6:0] expv;
  logic       found;
  int         px, py;

  vga_multiball_engine_if if4();
  vga_multiball_engine_if if1();

  vga_multiball_engine #(.N_BALLS(4), .RADIUS(20), .SHADOW_W(4),
                         .H_ACTIVE(640), .V_ACTIVE(480))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  vga_multiball_engine #(.N_BALLS(1), .RADIUS(20), .SHADOW_W(4),
                         .H_ACTIVE(640), .V_ACTIVE(480))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Free-running pixel clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one pixel on the 4-ball instance and waits out the 2-cycle latency.
  task automatic applyStimulus(input int x, input int y, input logic va, input logic [5:0] bg);
    @(negedge clk);
    if4.x = 10'(x);
    if4.y = 10'(y);
    if4.video_active = va;
    if4.bg_rgb = bg;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] palette(input int i);
    case (i)
      0:       return 6'b111000;
      1:       return 6'b001111;
      2:       return 6'b110011;
      default: return 6'b001100;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mbx[i] = 160 + 96 * i;
      mby[i] = 120 + 64 * i;
      mdx[i] = (i % 2 == 0) ? 1 : 0;
      mdy[i] = (i / 2) % 2;
    end
  endtask

  task automatic modelAxis(input int p, input int d, input int st, input int hi,
                           output int pn, output int dn);
    if (d == 1) begin
      if (p + st >= hi) begin pn = hi; dn = 0; end
      else begin pn = p + st; dn = 1; end
    end else begin
      if (p <= 20 + st) begin pn = 20; dn = 1; end
      else begin pn = p - st; dn = 0; end
    end
  endtask

  task automatic modelUpdate(input int speed);
    int s, pn, dn;
    s = (speed > 2) ? 2 : speed;
    for (int i = 0; i < 4; i++) begin
      modelAxis(mbx[i], mdx[i], (1 + i % 3) << s, 619, pn, dn);
      mbx[i] = pn; mdx[i] = dn;
      modelAxis(mby[i], mdy[i], (2 + i % 2) << s, 459, pn, dn);
      mby[i] = pn; mdy[i] = dn;
    end
  endtask

  // Returns {hit, rgb} for a visible pixel given the modelled positions.
  function automatic logic [6:0] expectedPixel(input int x, input int y, input logic [5:0] bg);
    logic [5:0] c;
    logic       h;
    int         d2;
    c = bg;
    h = 1'b0;
`ifdef VGA_BALL_SHADOW_EN
    for (int i = 0; i < 4; i++) begin
      d2 = (x - mbx[i]) * (x - mbx[i]) + (y - mby[i]) * (y - mby[i]);
      if (d2 <= 576) c = 6'b010101;
    end
`endif
    for (int i = 3; i >= 0; i--) begin
      d2 = (x - mbx[i]) * (x - mbx[i]) + (y - mby[i]) * (y - mby[i]);
      if (d2 <= 400) begin c = palette(i); h = 1'b1; end
    end
    return {h, c};
  endfunction

  task automatic pulseFrames(input logic do4, input logic do1);
    @(negedge clk);
    if4.frame_start = do4;
    if1.frame_start = do1;
    @(negedge clk);
    if4.frame_start = 1'b0;
    if1.frame_start = 1'b0;
    repeat (5) @(negedge clk);
    if (do4 && !if4.pause) modelUpdate(int'(if4.speed_sel));
  endtask

  initial begin
    if4.frame_start = 0; if4.x = 0; if4.y = 0; if4.video_active = 0;
    if4.bg_rgb = 0; if4.pause = 0; if4.speed_sel = 0;
    if1.frame_start = 0; if1.x = 0; if1.y = 0; if1.video_active = 0;
    if1.bg_rgb = 0; if1.pause = 0; if1.speed_sel = 0;
    modelReset();
    found = 1'b0;
    px = 0;
    py = 0;

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_rgb", 32'(if4.rgb), 0);
    checkOutput("rst_hit", 32'(if4.hit), 0);
    checkOutput("rst_busy", 32'(if4.update_busy), 0);
    checkOutput("rst_overrun", 32'(if4.overrun), 0);
    checkOutput("rst_bx3", 32'(dut4.balls_q[3].bx), 448);
    checkOutput("rst_by3", 32'(dut4.balls_q[3].by), 312);
    checkOutput("rst_dirx3", 32'(dut4.balls_q[3].dir_x), 0);
    checkOutput("rst_diry3", 32'(dut4.balls_q[3].dir_y), 1);

    // Reset release and frame_start together: the pulse must be dropped.
    @(negedge clk);
    rst_n = 1'b1;
    if4.frame_start = 1'b1;
    if1.frame_start = 1'b1;
    @(negedge clk);
    if4.frame_start = 1'b0;
    if1.frame_start = 1'b0;
    checkOutput("rel_busy4", 32'(if4.update_busy), 0);
    checkOutput("rel_busy1", 32'(if1.update_busy), 0);
    repeat (5) @(negedge clk);
    checkOutput("rel_bx0_4", 32'(dut4.balls_q[0].bx), 160);
    checkOutput("rel_bx0_1", 32'(dut1.balls_q[0].bx), 160);

    $display("[TB] pixel path");
    @(negedge clk);
    if4.x = 10'd160; if4.y = 10'd120; if4.video_active = 1'b1; if4.bg_rgb = 6'b000010;
    @(posedge clk); #1;
    checkOutput("lat1_rgb", 32'(if4.rgb), 0);
    @(posedge clk); #1;
    checkOutput("lat2_rgb", 32'(if4.rgb), 32'b111000);
    checkOutput("lat2_hit", 32'(if4.hit), 1);
    applyStimulus(300, 5, 1'b1, 6'b000010);
    checkOutput("bg_rgb", 32'(if4.rgb), 32'b000010);
    checkOutput("bg_hit", 32'(if4.hit), 0);
    applyStimulus(256, 184, 1'b1, 6'b000010);
    checkOutput("ball1_rgb", 32'(if4.rgb), 32'b001111);
    applyStimulus(352, 248, 1'b1, 6'b000010);
    checkOutput("ball2_rgb", 32'(if4.rgb), 32'b110011);
    applyStimulus(448, 312, 1'b1, 6'b000010);
    checkOutput("ball3_rgb", 32'(if4.rgb), 32'b001100);
    applyStimulus(180, 120, 1'b1, 6'b000010);
    checkOutput("edge20_rgb", 32'(if4.rgb), 32'b111000);
    checkOutput("edge20_hit", 32'(if4.hit), 1);
    applyStimulus(182, 120, 1'b1, 6'b000010);
`ifdef VGA_BALL_SHADOW_EN
    checkOutput("shadow22_rgb", 32'(if4.rgb), 32'b010101);
`else
    checkOutput("shadow22_rgb", 32'(if4.rgb), 32'b000010);
`endif
    checkOutput("shadow22_hit", 32'(if4.hit), 0);
    applyStimulus(160, 120, 1'b0, 6'b000010);
    checkOutput("blank_rgb", 32'(if4.rgb), 0);
    checkOutput("blank_hit", 32'(if4.hit), 0);

    $display("[TB] pause");
    if4.pause = 1'b1;
    @(negedge clk); if4.frame_start = 1'b1;
    @(negedge clk); if4.frame_start = 1'b0;
    checkOutput("pause_busy", 32'(if4.update_busy), 0);
    repeat (5) @(negedge clk);
    checkOutput("pause_bx0", 32'(dut4.balls_q[0].bx), 160);
    checkOutput("pause_by2", 32'(dut4.balls_q[2].by), 248);
    if4.pause = 1'b0;

    $display("[TB] overrun");
    checkOutput("ovr_before", 32'(if4.overrun), 0);
    @(negedge clk); if4.frame_start = 1'b1;
    @(negedge clk); if4.frame_start = 1'b0; if4.pause = 1'b1;
    checkOutput("ovr_busy1", 32'(if4.update_busy), 1);
    @(negedge clk); if4.frame_start = 1'b1;
    @(negedge clk); if4.frame_start = 1'b0;
    checkOutput("ovr_flag", 32'(if4.overrun), 1);
    checkOutput("ovr_busy3", 32'(if4.update_busy), 1);
    repeat (3) @(negedge clk);
    checkOutput("ovr_done", 32'(if4.update_busy), 0);
    if4.pause = 1'b0;
    modelUpdate(0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovr_bx%0d", i), 32'(dut4.balls_q[i].bx), 32'(mbx[i]));
      checkOutput($sformatf("ovr_by%0d", i), 32'(dut4.balls_q[i].by), 32'(mby[i]));
    end

    $display("[TB] overlap search");
    for (int f = 0; f < 3000 && !found; f++) begin
      pulseFrames(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
        for (int j = i + 1; j < 4; j++) begin
          int mx, my, di, dj;
          mx = (mbx[i] + mbx[j]) / 2;
          my = (mby[i] + mby[j]) / 2;
          di = (mx - mbx[i]) * (mx - mbx[i]) + (my - mby[i]) * (my - mby[i]);
          dj = (mx - mbx[j]) * (mx - mbx[j]) + (my - mby[j]) * (my - mby[j]);
          if (!found && di <= 400 && dj <= 400) begin
            found = 1'b1; px = mx; py = my;
          end
        end
      end
    end
    checkOutput("overlap_found", 32'(found), 1);
    if (found) begin
      applyStimulus(px, py, 1'b1, 6'b000001);
      expv = expectedPixel(px, py, 6'b000001);
      checkOutput("overlap_rgb", 32'(if4.rgb), 32'(expv[5:0]));
      checkOutput("overlap_hit", 32'(if4.hit), 1);
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("trk_bx%0d", i), 32'(dut4.balls_q[i].bx), 32'(mbx[i]));
    end

    $display("[TB] wall bounce");
    if1.speed_sel = 2'd0;
    repeat (458) pulseFrames(1'b0, 1'b1);
    checkOutput("b1_618", 32'(dut1.balls_q[0].bx), 618);
    checkOutput("b1_618_dir", 32'(dut1.balls_q[0].dir_x), 1);
    pulseFrames(1'b0, 1'b1);
    checkOutput("b1_619", 32'(dut1.balls_q[0].bx), 619);
    checkOutput("b1_619_dir", 32'(dut1.balls_q[0].dir_x), 0);
    pulseFrames(1'b0, 1'b1);
    checkOutput("b1_back618", 32'(dut1.balls_q[0].bx), 618);
    pulseFrames(1'b0, 1'b1);
    if1.speed_sel = 2'd1;
    repeat (298) pulseFrames(1'b0, 1'b1);
    checkOutput("b1_21", 32'(dut1.balls_q[0].bx), 21);
    checkOutput("b1_21_dir", 32'(dut1.balls_q[0].dir_x), 0);
    pulseFrames(1'b0, 1'b1);
    checkOutput("b1_20", 32'(dut1.balls_q[0].bx), 20);
    checkOutput("b1_20_dir", 32'(dut1.balls_q[0].dir_x), 1);
    pulseFrames(1'b0, 1'b1);
    checkOutput("b1_22", 32'(dut1.balls_q[0].bx), 22);
    if1.speed_sel = 2'd3;
    pulseFrames(1'b0, 1'b1);
    checkOutput("b1_sel3", 32'(dut1.balls_q[0].bx), 26);

    $display("[TB] reset during update");
    @(negedge clk); if4.frame_start = 1'b1;
    @(negedge clk); if4.frame_start = 1'b0;
    checkOutput("mid_busy", 32'(if4.update_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(if4.update_busy), 0);
    checkOutput("mid_rst_overrun", 32'(if4.overrun), 0);
    checkOutput("mid_rst_bx0", 32'(dut4.balls_q[0].bx), 160);
    checkOutput("mid_rst_by1", 32'(dut4.balls_q[1].by), 184);
    checkOutput("mid_rst_dirx1", 32'(dut4.balls_q[1].dir_x), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
